// File: rtl/bcd8421_dec.sv
`default_nettype none
// ============================================================================
//  Module   : bcd8421_dec
//  Brief    : Serial multi-digit 8421 BCD to binary decoder with one-hot view
//             of the last accepted digit and sticky illegal-digit flag.
//  Revision : 1.0  initial release
// ============================================================================
module bcd8421_dec #(
    parameter int NDIGITS = 4,
    parameter int OUT_W   = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       digit_in,
    input  logic             digit_valid,
    output logic             digit_ready,
    output logic [OUT_W-1:0] bin_out,
    output logic             bin_valid,
    input  logic             bin_ready,
    output logic [8:0]       onehot_out,
    output logic             err
);

    localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(NDIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t           r_state;
    logic [OUT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] w_acc_next;
    logic [8:0]       w_onehot;
    logic             w_illegal;

    assign digit_ready = (r_state == S_ACCUM);
    assign w_illegal   = (digit_in > 4'd9);
    // acc*10 as two shifts; OUT_W is sized so this never wraps
    assign w_acc_next  = (r_acc << 3) + (r_acc << 1) + OUT_W'(digit_in);

    always_comb begin
        w_onehot = '0;
        for (int i = 1; i <= 9; i++) begin
            if (digit_in == 4'(i)) begin
                w_onehot[i-1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            bin_out    <= '0;
            bin_valid  <= 1'b0;
            onehot_out <= '0;
            err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ACCUM;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        err     <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    // a restart wins over any digit offered in the same cycle
                    if (start) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end else if (digit_valid) begin
                        if (w_illegal) begin
                            err     <= 1'b1;
                            r_state <= S_ERR;
                        end else begin
                            r_acc      <= w_acc_next;
                            onehot_out <= w_onehot;
                            if (r_cnt == c_last_cnt) begin
                                r_cnt     <= '0;
                                bin_out   <= w_acc_next;
                                bin_valid <= 1'b1;
                                r_state   <= S_DONE;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    // start alone is ignored so a pending result is never lost
                    if (bin_ready) begin
                        bin_valid <= 1'b0;
                        if (start) begin
                            r_state <= S_ACCUM;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_ERR: begin
                    if (start) begin
                        r_state <= S_ACCUM;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        err     <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd8421_dec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd8421_dec
//  Brief    : Directed bench for bcd8421_dec with a decimal-arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd8421_dec;

    localparam int NDIGITS = 4;
    localparam int OUT_W   = 14;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       digit_in;
    logic             digit_valid;
    logic             digit_ready;
    logic [OUT_W-1:0] bin_out;
    logic             bin_valid;
    logic             bin_ready;
    logic [8:0]       onehot_out;
    logic             err;

    int tests = 0;
    int fails = 0;

    bcd8421_dec #(.NDIGITS(NDIGITS), .OUT_W(OUT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .bin_out     (bin_out),
        .bin_valid   (bin_valid),
        .bin_ready   (bin_ready),
        .onehot_out  (onehot_out),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [8:0] onehot_of(input int d);
        logic [8:0] one;
        one = 9'd1;
        if (d <= 0) return 9'd0;
        return one << (d - 1);
    endfunction

    // Decimal model: value accumulated with plain *10 arithmetic
    bit m_coll, m_hold, m_bad, m_bv;
    int m_val, m_n, m_bin, m_last;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_coll <= 0; m_hold <= 0; m_bad <= 0; m_bv <= 0;
            m_val  <= 0; m_n    <= 0; m_bin <= 0; m_last <= -1;
        end else if (m_coll) begin
            if (start) begin
                m_val <= 0; m_n <= 0;
            end else if (digit_valid) begin
                if (digit_in > 9) begin
                    m_bad <= 1; m_coll <= 0;
                end else begin
                    m_val  <= m_val * 10 + int'(digit_in);
                    m_last <= int'(digit_in);
                    m_n    <= m_n + 1;
                    if (m_n + 1 == NDIGITS) begin
                        m_bin  <= m_val * 10 + int'(digit_in);
                        m_bv   <= 1; m_coll <= 0; m_hold <= 1;
                    end
                end
            end
        end else if (m_hold) begin
            if (bin_ready) begin
                m_bv <= 0; m_hold <= 0;
                if (start) begin
                    m_coll <= 1; m_val <= 0; m_n <= 0;
                end
            end
        end else if (start) begin
            m_coll <= 1; m_val <= 0; m_n <= 0; m_bad <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_bin_out",     32'(bin_out),     32'(m_bin));
            check("cyc_bin_valid",   32'(bin_valid),   32'(m_bv));
            check("cyc_digit_ready", 32'(digit_ready), 32'(m_coll));
            check("cyc_onehot",      32'(onehot_out),  32'(onehot_of(m_last)));
            check("cyc_err",         32'(err),         32'(m_bad));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] d, input int gap);
        digit_in    = d;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic consume();
        bin_ready = 1'b1;
        tick();
        bin_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; digit_in = 4'd0; digit_valid = 1'b0; bin_ready = 1'b0;
        #1;
        check("rst_bin_out",     32'(bin_out),     32'd0);
        check("rst_bin_valid",   32'(bin_valid),   32'd0);
        check("rst_onehot",      32'(onehot_out),  32'd0);
        check("rst_err",         32'(err),         32'd0);
        check("rst_digit_ready", 32'(digit_ready), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("idle_digit_ready", 32'(digit_ready), 32'd0);

        // 1,2,3,4 back-to-back
        pulse_start();
        send(4'd1, 0); send(4'd2, 0); send(4'd3, 0);
        check("t2_no_valid_early", 32'(bin_valid), 32'd0);
        send(4'd4, 0);
        check("t2_bin_valid", 32'(bin_valid),  32'd1);
        check("t2_bin_out",   32'(bin_out),    32'h04D2);
        check("t2_onehot",    32'(onehot_out), 32'b000001000);
        check("t2_done_ready", 32'(digit_ready), 32'd0);
        consume();
        check("t2_consumed", 32'(bin_valid), 32'd0);
        check("t2_retained", 32'(bin_out),   32'h04D2);

        // 9,9,9,9 with gaps, then a run starting with 0
        pulse_start();
        for (int i = 0; i < 4; i++) send(4'd9, 2);
        check("t3_bin_out", 32'(bin_out),    32'h270F);
        check("t3_onehot9", 32'(onehot_out), 32'b100000000);
        consume();
        pulse_start();
        send(4'd0, 0);
        check("t3_onehot0", 32'(onehot_out), 32'd0);
        send(4'd0, 1); send(4'd0, 0); send(4'd0, 0);
        check("t3_zero", 32'(bin_out), 32'd0);
        consume();

        // illegal digit
        pulse_start();
        send(4'd5, 0); send(4'hB, 0);
        check("t4_err",         32'(err),         32'd1);
        check("t4_no_valid",    32'(bin_valid),   32'd0);
        check("t4_err_ready",   32'(digit_ready), 32'd0);
        check("t4_onehot_kept", 32'(onehot_out),  32'b000010000);
        pulse_start();
        check("t4_err_clear", 32'(err), 32'd0);
        send(4'd0, 0); send(4'd0, 0); send(4'd0, 0); send(4'd7, 0);
        check("t4_bin_out", 32'(bin_out), 32'd7);

        // result held with back-pressure; start ignored
        tick(); tick();
        pulse_start();
        tick(); tick();
        check("t5_hold_valid", 32'(bin_valid),   32'd1);
        check("t5_hold_out",   32'(bin_out),     32'd7);
        check("t5_hold_ready", 32'(digit_ready), 32'd0);
        consume();
        check("t5_released", 32'(bin_valid), 32'd0);

        // start together with result take goes straight to accumulating
        pulse_start();
        send(4'd1, 0); send(4'd0, 0); send(4'd0, 0); send(4'd1, 0);
        check("t5b_bin_out", 32'(bin_out), 32'd1001);
        start = 1'b1; bin_ready = 1'b1;
        tick();
        start = 1'b0; bin_ready = 1'b0;
        check("t5b_accum", 32'(digit_ready), 32'd1);
        check("t5b_taken", 32'(bin_valid),   32'd0);

        // restart mid-run, start-cycle digit discarded
        send(4'd3, 0); send(4'd8, 0);
        start = 1'b1; digit_valid = 1'b1; digit_in = 4'd6;
        tick();
        start = 1'b0; digit_valid = 1'b0;
        send(4'd0, 0); send(4'd0, 0); send(4'd4, 0); send(4'd2, 0);
        check("t6_bin_out", 32'(bin_out), 32'd42);
        consume();

        // reset mid-run
        pulse_start();
        send(4'd1, 0); send(4'd2, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_onehot", 32'(onehot_out),  32'd0);
        check("t6_rst_bin",    32'(bin_out),     32'd0);
        check("t6_rst_ready",  32'(digit_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        send(4'd3, 0); send(4'd4, 0);
        tick();
        check("t6_no_valid", 32'(bin_valid), 32'd0);
        check("t6_idle",     32'(digit_ready), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
